// File: rtl/audio_add_sub.sv
// Audio add/sub matrix: converts an (L+R, L-R) sample stream into
// (left, right) = (L+R + L-R, L+R - L-R). It pops both input FIFOs in
// lock-step, holds the result, and pushes it into both output FIFOs in
// lock-step. Arithmetic is two's-complement and wraps without saturation.
module audio_add_sub #(
   parameter int DATA_SIZE = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 lpr_empty,
   output logic                 lpr_rd_en,
   input  logic [DATA_SIZE-1:0] lpr_dout,
   input  logic                 lmr_empty,
   output logic                 lmr_rd_en,
   input  logic [DATA_SIZE-1:0] lmr_dout,
   input  logic                 left_full,
   output logic                 left_wr_en,
   output logic [DATA_SIZE-1:0] left_din,
   input  logic                 right_full,
   output logic                 right_wr_en,
   output logic [DATA_SIZE-1:0] right_din,
   output logic [31:0]          sample_count
);

   typedef enum logic [0:0] {
      S_READ  = 1'b0,
      S_WRITE = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [DATA_SIZE-1:0] left_q,  left_d;
   logic [DATA_SIZE-1:0] right_q, right_d;
   logic [31:0]          count_q, count_d;
   logic                 rd_fire_s;
   logic                 wr_fire_s;

   // Handshake qualifiers: pop only when both inputs have data, push only
   // when both outputs have room; reset masks both so no strobe leaks out
   // while the block is held in reset.
   always_comb begin
      rd_fire_s = reset & (state_q == S_READ)  & ~lpr_empty & ~lmr_empty;
      wr_fire_s = reset & (state_q == S_WRITE) & ~left_full & ~right_full;
   end

   // Next-state and datapath: capture sum/difference on a pop, count on a push.
   always_comb begin
      state_d = state_q;
      left_d  = left_q;
      right_d = right_q;
      count_d = count_q;
      case (state_q)
         S_READ: begin
            if (rd_fire_s) begin
               left_d  = lpr_dout + lmr_dout;
               right_d = lpr_dout - lmr_dout;
               state_d = S_WRITE;
            end else begin
               state_d = S_READ;
            end
         end
         S_WRITE: begin
            if (wr_fire_s) begin
               count_d = count_q + 32'd1;
               state_d = S_READ;
            end else begin
               state_d = S_WRITE;
            end
         end
         default: begin
            state_d = S_READ;
         end
      endcase
   end

   // State and output registers; reset drops any held pair without pushing it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_READ;
         left_q  <= {DATA_SIZE{1'b0}};
         right_q <= {DATA_SIZE{1'b0}};
         count_q <= 32'd0;
      end else begin
         state_q <= state_d;
         left_q  <= left_d;
         right_q <= right_d;
         count_q <= count_d;
      end
   end

   assign lpr_rd_en    = rd_fire_s;
   assign lmr_rd_en    = rd_fire_s;
   assign left_wr_en   = wr_fire_s;
   assign right_wr_en  = wr_fire_s;
   assign left_din     = left_q;
   assign right_din    = right_q;
   assign sample_count = count_q;

endmodule

// File: tb/tb_audio_add_sub.sv
// Self-checking bench for audio_add_sub: FIFO-like sources/sinks, a queue
// based reference model (pairs popped but not yet pushed), directed cases
// with literal expectations, and a randomized stream with empty/full toggling.
module tb_audio_add_sub;
   localparam int W = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic          lpr_empty, lpr_rd_en, lmr_empty, lmr_rd_en;
   logic [W-1:0]  lpr_dout, lmr_dout;
   logic          left_full, left_wr_en, right_full, right_wr_en;
   logic [W-1:0]  left_din, right_din;
   logic [31:0]   sample_count;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] src_a[$];
   logic [W-1:0] src_b[$];
   int           pop_idx   = 0;
   logic [W-1:0] exp_l[$];
   logic [W-1:0] exp_r[$];
   int           exp_count = 0;
   logic         rst_req   = 1'b0;
   logic         lpr_blk   = 1'b0;
   logic         lmr_blk   = 1'b0;
   logic         lf        = 1'b0;
   logic         rf        = 1'b0;
   logic [W-1:0] last_l    = '0;
   logic [W-1:0] last_r    = '0;
   int           rd_seen   = 0;
   int           wr_seen   = 0;

   audio_add_sub #(.DATA_SIZE(W)) dut (
      .clock(clock), .reset(reset),
      .lpr_empty(lpr_empty), .lpr_rd_en(lpr_rd_en), .lpr_dout(lpr_dout),
      .lmr_empty(lmr_empty), .lmr_rd_en(lmr_rd_en), .lmr_dout(lmr_dout),
      .left_full(left_full), .left_wr_en(left_wr_en), .left_din(left_din),
      .right_full(right_full), .right_wr_en(right_wr_en), .right_din(right_din),
      .sample_count(sample_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // One clock cycle: check registered outputs, drive inputs, check strobes,
   // then advance the model for the coming rising edge.
   task automatic step();
      logic exp_rd, exp_wr;
      @(negedge clock);
      chk("sample_count", sample_count, exp_count);
      if (!reset) begin
         chk("left_din_rst", left_din, 0);
         chk("right_din_rst", right_din, 0);
      end else if (exp_l.size() != 0) begin
         chk("left_din_held", left_din, exp_l[0]);
         chk("right_din_held", right_din, exp_r[0]);
      end
      reset      = rst_req;
      lpr_empty  = (pop_idx >= src_a.size()) || lpr_blk;
      lmr_empty  = (pop_idx >= src_a.size()) || lmr_blk;
      lpr_dout   = lpr_empty ? W'($urandom) : src_a[pop_idx];
      lmr_dout   = lmr_empty ? W'($urandom) : src_b[pop_idx];
      left_full  = lf;
      right_full = rf;
      #1;
      exp_rd = reset && (exp_l.size() == 0) && !lpr_empty && !lmr_empty;
      exp_wr = reset && (exp_l.size() != 0) && !lf && !rf;
      chk("lpr_rd_en", lpr_rd_en, exp_rd);
      chk("lmr_rd_en", lmr_rd_en, exp_rd);
      chk("left_wr_en", left_wr_en, exp_wr);
      chk("right_wr_en", right_wr_en, exp_wr);
      if (lpr_rd_en) rd_seen++;
      if (left_wr_en) wr_seen++;
      if (exp_wr) begin
         last_l = left_din;
         last_r = right_din;
         void'(exp_l.pop_front());
         void'(exp_r.pop_front());
         exp_count++;
      end
      if (exp_rd) begin
         exp_l.push_back(src_a[pop_idx] + src_b[pop_idx]);
         exp_r.push_back(src_a[pop_idx] - src_b[pop_idx]);
         pop_idx++;
      end
   endtask

   task automatic run_until_idle(input int budget, input bit randomize_flags);
      int n = 0;
      while ((pop_idx < src_a.size() || exp_l.size() != 0) && n < budget) begin
         if (randomize_flags) begin
            lpr_blk = ($urandom_range(3) == 0);
            lmr_blk = ($urandom_range(3) == 0);
            lf      = ($urandom_range(3) == 0);
            rf      = ($urandom_range(3) == 0);
         end
         step();
         n++;
      end
      lpr_blk = 1'b0; lmr_blk = 1'b0; lf = 1'b0; rf = 1'b0;
      chk("drain_timeout", (pop_idx < src_a.size() || exp_l.size() != 0), 0);
   endtask

   task automatic wait_holding(input int budget);
      int n = 0;
      while (exp_l.size() == 0 && n < budget) begin
         step();
         n++;
      end
      chk("hold_timeout", exp_l.size() != 0, 1);
   endtask

   // Asynchronous reset assertion between clock edges; outputs must clear at once.
   task automatic async_reset();
      @(posedge clock);
      #2;
      rst_req = 1'b0;
      reset   = 1'b0;
      #1;
      chk("rst_left_din", left_din, 0);
      chk("rst_right_din", right_din, 0);
      chk("rst_count", sample_count, 0);
      chk("rst_rd_en", {lpr_rd_en, lmr_rd_en}, 0);
      chk("rst_wr_en", {left_wr_en, right_wr_en}, 0);
      exp_l.delete();
      exp_r.delete();
      exp_count = 0;
      repeat (3) step();
      rst_req = 1'b1;
   endtask

   initial begin
      int rd0, wr0;
      reset = 1'b0; lpr_empty = 1'b1; lmr_empty = 1'b1; left_full = 1'b0; right_full = 1'b0;
      lpr_dout = '0; lmr_dout = '0;

      // Reset with clock running and data available: nothing moves.
      src_a.push_back(32'h0000_0010); src_b.push_back(32'h0000_0004);
      repeat (4) step();
      chk("no_pop_in_reset", rd_seen, 0);
      rst_req = 1'b1;

      // Basic pair.
      run_until_idle(20, 1'b0);
      step();
      chk("basic_left", last_l, 32'h0000_0014);
      chk("basic_right", last_r, 32'h0000_000C);
      chk("basic_count", sample_count, 32'd1);
      chk("basic_wr_pulses", wr_seen, 1);

      // Signed / wrapping cases.
      src_a.push_back(32'hFFFF_FFFF); src_b.push_back(32'h0000_0001);
      run_until_idle(20, 1'b0);
      chk("wrap1_left", last_l, 32'h0000_0000);
      chk("wrap1_right", last_r, 32'hFFFF_FFFE);
      src_a.push_back(32'h7FFF_FFFF); src_b.push_back(32'h0000_0001);
      run_until_idle(20, 1'b0);
      chk("wrap2_left", last_l, 32'h8000_0000);
      chk("wrap2_right", last_r, 32'h7FFF_FFFE);

      // Input skew: L-R empty for 5 cycles.
      lmr_blk = 1'b1;
      src_a.push_back(32'h0000_0005); src_b.push_back(32'h0000_0003);
      rd0 = rd_seen;
      repeat (5) step();
      chk("skew_no_pop", rd_seen - rd0, 0);
      lmr_blk = 1'b0;
      step();
      chk("skew_pop_first", rd_seen - rd0, 1);
      run_until_idle(20, 1'b0);
      chk("skew_left", last_l, 32'h0000_0008);
      chk("skew_right", last_r, 32'h0000_0002);

      // Backpressure: right full for 10 cycles while holding, more input queued.
      rf = 1'b1;
      src_a.push_back(32'h0000_0100); src_b.push_back(32'h0000_0001);
      src_a.push_back(32'h0000_0200); src_b.push_back(32'h0000_0002);
      wait_holding(10);
      rd0 = rd_seen; wr0 = wr_seen;
      repeat (10) step();
      chk("bp_no_push", wr_seen - wr0, 0);
      chk("bp_no_pop", rd_seen - rd0, 0);
      rf = 1'b0;
      step();
      chk("bp_release_push", wr_seen - wr0, 1);
      chk("bp_left", last_l, 32'h0000_0101);
      chk("bp_right", last_r, 32'h0000_00FF);
      run_until_idle(20, 1'b0);

      // Reset while a pair is held: that pair must never be written.
      lf = 1'b1;
      src_a.push_back(32'h0000_0020); src_b.push_back(32'h0000_0002);
      wait_holding(10);
      wr0 = wr_seen;
      async_reset();
      lf = 1'b0;
      src_a.push_back(32'h0000_0030); src_b.push_back(32'h0000_0003);
      run_until_idle(20, 1'b0);
      chk("rst_mid_one_push", wr_seen - wr0, 1);
      chk("rst_mid_left", last_l, 32'h0000_0033);
      chk("rst_mid_right", last_r, 32'h0000_002D);

      // Random stream of 200 pairs with random empty/full toggling.
      async_reset();
      wr0 = wr_seen;
      for (int i = 0; i < 200; i++) begin
         src_a.push_back(W'($urandom));
         src_b.push_back(W'($urandom));
      end
      run_until_idle(5000, 1'b1);
      step();
      chk("stream_pushes", wr_seen - wr0, 200);
      chk("stream_count", sample_count, 32'd200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
